// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared state type, line constants and counter sizing for the SIPO frame receiver
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // A one-bit counter is still needed when WIDTH is small enough for $clog2 to return 0.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sipo_shifter.sv
// rtl/sipo_shifter.sv - WIDTH-bit left-shift register, new serial bit enters at the LSB
module sipo_shifter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], sin};
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// rtl/sipo_frame_ctrl.sv - framed serial receiver: start hunt, data shift, even parity, stop check,
// and a single-entry valid/ready output slot
module sipo_frame_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic perr;

  logic shift_en, cnt_clr, cnt_inc, perr_load, stop_eval;
  logic slot_free, handshake, stop_ok, word_good, load;

  sipo_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .sin      (sin),
    .q        (shreg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    shift_en  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    perr_load = 1'b0;
    stop_eval = 1'b0;
    if (bit_en) begin
      unique case (state)
        IDLE: begin
          if (sin == START_BIT) begin
            state_d = SHIFT;
            cnt_clr = 1'b1;
          end
        end
        SHIFT: begin
          shift_en = 1'b1;
          if (cnt == CNT_LAST) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        PARITY: begin
          perr_load = 1'b1;
          state_d   = STOP;
        end
        STOP: begin
          stop_eval = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // perr is cleared at each start so frames without a parity bit never report one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      perr <= 1'b0;
    end else begin
      if (cnt_clr) begin
        cnt  <= '0;
        perr <= 1'b0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (perr_load) begin
        perr <= (^shreg) ^ sin;
      end
    end
  end

  assign handshake = dout_valid & dout_ready;
  assign slot_free = ~dout_valid | dout_ready;
  assign stop_ok   = stop_eval & (sin == STOP_BIT);
  assign word_good = stop_ok & ~perr;
  assign load      = word_good & slot_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= stop_eval & (sin != STOP_BIT);
      parity_err <= stop_ok & perr;
      overrun    <= word_good & ~slot_free;
      if (load) begin
        dout       <= shreg;
        dout_valid <= 1'b1;
      end else if (handshake) begin
        dout_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
